// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer.
//   - tw_width(): twiddle ROM index width for a given LOG_N (LOG_N-1, min 1)
//   - state_t  : sequencer states
//   - BF_LATENCY / ISSUE_INTERVAL: butterfly pipeline timing
package fft_pkg;

   localparam int BF_LATENCY     = 5;  // x_nd -> y_nd
   localparam int ISSUE_INTERVAL = 2;  // butterfly accepts one input every 2 cycles

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int tw_width(input int log_n);
      return (log_n > 1) ? log_n - 1 : 1;
   endfunction

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// Handshake/bus bundle between the FFT sequencer and its environment
// (sample buffer, twiddle ROM, butterfly).
//   master : sequencer side (drives strobes/addresses, receives start and
//            butterfly outputs)
//   slave  : environment side
// Optional: FFT_STAGE_CTRL_INVERSE_EN adds inverse (in) and tw_conj (out).
interface fft_stage_ctrl_if
   import fft_pkg::*;
#(
   parameter int LOG_N  = 3,
   parameter int A_WDTH = LOG_N
) ();
   localparam int TW_WDTH = tw_width(LOG_N);

   logic                  start;
   logic                  busy;
   logic                  done;
   logic [LOG_N-1:0]      stage;
   logic                  rd_en;
   logic [A_WDTH-1:0]     rd_addr_a;
   logic [A_WDTH-1:0]     rd_addr_b;
   logic [TW_WDTH-1:0]    tw_addr;
   logic                  bf_x_nd;
   logic [2*A_WDTH-1:0]   bf_m_in;
   logic [2*A_WDTH-1:0]   bf_m_out;
   logic                  bf_y_nd;
   logic                  wr_en;
   logic [A_WDTH-1:0]     wr_addr;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
   logic                  inverse;
   logic                  tw_conj;

   modport master (
      input  start, bf_m_out, bf_y_nd, inverse,
      output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
             bf_x_nd, bf_m_in, wr_en, wr_addr, tw_conj
   );
   modport slave (
      output start, bf_m_out, bf_y_nd, inverse,
      input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
             bf_x_nd, bf_m_in, wr_en, wr_addr, tw_conj
   );
`else
   modport master (
      input  start, bf_m_out, bf_y_nd,
      output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
             bf_x_nd, bf_m_in, wr_en, wr_addr
   );
   modport slave (
      output start, bf_m_out, bf_y_nd,
      input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
             bf_x_nd, bf_m_in, wr_en, wr_addr
   );
`endif
endinterface

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT in-place address mapping for stage s, butterfly k.
//   s       in  stage index
//   k       in  butterfly index within the stage (0..N/2-1)
//   addr_a  out XA address: k with a zero inserted at bit position s
//   addr_b  out XB address: addr_a + 2^s
//   tw_addr out twiddle index: (k mod 2^s) scaled to the N/2-entry ROM
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter int LOG_N   = 3,
   parameter int A_WDTH  = LOG_N,
   parameter int TW_WDTH = tw_width(LOG_N)
) (
   input  logic [LOG_N-1:0]   s,
   input  logic [TW_WDTH-1:0] k,
   output logic [A_WDTH-1:0]  addr_a,
   output logic [A_WDTH-1:0]  addr_b,
   output logic [TW_WDTH-1:0] tw_addr
);
   logic [A_WDTH-1:0] kk;
   logic [A_WDTH-1:0] half;
   logic [A_WDTH-1:0] pos;
   logic [LOG_N-1:0]  tw_shamt;

   always_comb begin
      kk       = A_WDTH'(k);
      half     = A_WDTH'(1) << s;
      pos      = kk & (half - 1'b1);
      addr_a   = ((kk >> s) << (s + 1'b1)) | pos;
      addr_b   = addr_a + half;
      tw_shamt = LOG_N'(LOG_N - 1) - s;
      // pos < 2^s <= N/2, so it always fits the ROM index width
      tw_addr  = TW_WDTH'(pos) << tw_shamt;
   end
endmodule

// File: rtl/fft_stage_ctrl.sv
// Sequencer for one shared radix-2 butterfly running an in-place DIT FFT.
// Each stage issues N/2 butterflies, one every 2 cycles (read, then x_nd),
// writes YA/YB back on consecutive cycles as results return, and drains the
// butterfly before the next stage so no stale data is read.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       fft_stage_ctrl_if.master: start/busy/done/stage, buffer read
//             (rd_en, rd_addr_a/b), twiddle index, butterfly x_nd/m_in,
//             m_out/y_nd, buffer write (wr_en, wr_addr)
// Optional: FFT_STAGE_CTRL_INVERSE_EN -- inverse sampled on accepted start,
//           tw_conj held for the run so the ROM wrapper conjugates W.
module fft_stage_ctrl
   import fft_pkg::*;
#(
   parameter int LOG_N  = 3,
   parameter int A_WDTH = LOG_N
) (
   input  logic            clk,
   input  logic            rst,
   fft_stage_ctrl_if.master bus
);
   localparam int TW_WDTH = tw_width(LOG_N);
   // enough headroom for every butterfly that can be in flight
   localparam int OUT_W = $clog2(BF_LATENCY / ISSUE_INTERVAL + 2) + 1;
   localparam logic [TW_WDTH-1:0] K_LAST     = TW_WDTH'((1 << (LOG_N - 1)) - 1);
   localparam logic [LOG_N-1:0]   STAGE_LAST = LOG_N'(LOG_N - 1);

   state_t               state_q, state_d;
   logic [LOG_N-1:0]     stage_q, stage_d;
   logic [TW_WDTH-1:0]   k_q, k_d;
   logic                 phase_q, phase_d;   // 0: read, 1: x_nd
   logic [OUT_W-1:0]     out_q, out_d;       // butterflies issued, YB not yet written
   logic                 yb_pend_q;
   logic [A_WDTH-1:0]    addr_b_lat_q;
   logic                 err_q;

   logic                 rd_en, x_nd, wr_ya, wr_yb, drain_clear;
   logic [A_WDTH-1:0]    addr_a, addr_b;
   logic [TW_WDTH-1:0]   tw_raw;

   fft_addr_gen #(
      .LOG_N   (LOG_N),
      .A_WDTH  (A_WDTH),
      .TW_WDTH (TW_WDTH)
   ) u_addr_gen (
      .s       (stage_q),
      .k       (k_q),
      .addr_a  (addr_a),
      .addr_b  (addr_b),
      .tw_addr (tw_raw)
   );

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      k_d     = k_q;
      phase_d = phase_q;
      rd_en   = 1'b0;
      x_nd    = 1'b0;
      wr_ya   = bus.bf_y_nd && (state_q != IDLE);
      wr_yb   = yb_pend_q;
      // Look at the post-write count so the next stage's first read lands
      // the cycle right after the final YB write.
      drain_clear = (out_q == '0) || ((out_q == OUT_W'(1)) && wr_yb);

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ISSUE;
               stage_d = '0;
               k_d     = '0;
               phase_d = 1'b0;
            end
         end
         ISSUE: begin
            if (!phase_q) begin
               rd_en   = 1'b1;
               phase_d = 1'b1;
            end else begin
               x_nd    = 1'b1;
               phase_d = 1'b0;
               if (k_q == K_LAST) begin
                  k_d     = '0;
                  state_d = DRAIN;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (drain_clear) begin
               if (stage_q == STAGE_LAST) begin
                  state_d = DONE;
               end else begin
                  stage_d = stage_q + 1'b1;
                  k_d     = '0;
                  phase_d = 1'b0;
                  state_d = ISSUE;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      out_d = out_q + OUT_W'(x_nd) - OUT_W'(wr_yb);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         stage_q      <= '0;
         k_q          <= '0;
         phase_q      <= 1'b0;
         out_q        <= '0;
         yb_pend_q    <= 1'b0;
         addr_b_lat_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q   <= state_d;
         stage_q   <= stage_d;
         k_q       <= k_d;
         phase_q   <= phase_d;
         out_q     <= out_d;
         yb_pend_q <= wr_ya;
         if (wr_ya) addr_b_lat_q <= bus.bf_m_out[A_WDTH-1:0];
         // sticky: a result arrived with nothing outstanding
         err_q <= err_q | (wr_ya && (out_q == '0));
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.stage     = stage_q;
   assign bus.rd_en     = rd_en;
   assign bus.rd_addr_a = rd_en ? addr_a : '0;
   assign bus.rd_addr_b = rd_en ? addr_b : '0;
   assign bus.tw_addr   = rd_en ? tw_raw : '0;
   assign bus.bf_x_nd   = x_nd;
   assign bus.bf_m_in   = x_nd ? {addr_a, addr_b} : '0;
   assign bus.wr_en     = wr_ya | wr_yb;
   assign bus.wr_addr   = wr_yb ? addr_b_lat_q :
                          wr_ya ? bus.bf_m_out[2*A_WDTH-1:A_WDTH] : '0;

`ifdef FFT_STAGE_CTRL_INVERSE_EN
   logic tw_conj_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    tw_conj_q <= 1'b0;
      else if ((state_q == IDLE) && bus.start)    tw_conj_q <= bus.inverse;
   end
   assign bus.tw_conj = tw_conj_q;
`endif
endmodule

// File: tb/tb_fft_stage_ctrl.sv
module tb_fft_stage_ctrl;
   localparam int LOG_N = 3;
   localparam int N     = 1 << LOG_N;
   localparam int AW    = LOG_N;

   typedef struct { int cyc; int a; int b; int tw; int s; } rd_t;
   typedef struct { int cyc; int v; } ev_t;

   logic clk, rst;
   fft_stage_ctrl_if #(.LOG_N(LOG_N), .A_WDTH(AW)) bus ();
   fft_stage_ctrl #(.LOG_N(LOG_N), .A_WDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nchk = 0, npass = 0;
   int cyc = 0;
   rd_t rq[$];
   ev_t xq[$], wq[$];
   bit  run_active = 0;
   int  t0_run = 0, done_cyc = 0, s0_first = -1, s2_first = -1;
   bit  inv_next = 0, inv_run = 0;
   bit  dly_v [5];
   logic [2*AW-1:0] dly_m [5];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // expected events of a full run accepted at cycle t
   task automatic sched(input int t);
      int half, base, k, a, b;
      t0_run = t; run_active = 1; done_cyc = t + 1 + LOG_N * (N + 6);
      s0_first = -1; s2_first = -1; inv_run = inv_next;
      for (int s = 0; s < LOG_N; s++) begin
         half = 1 << s; base = t + 1 + s * (N + 6); k = 0;
         for (int g = 0; g < N; g += 2 * half)
            for (int j = 0; j < half; j++) begin
               a = g + j; b = a + half;
               rq.push_back('{base + 2*k, a, b, j * (N / (2*half)), s});
               xq.push_back('{base + 2*k + 1, (a << AW) | b});
               wq.push_back('{base + 2*k + 6, a});
               wq.push_back('{base + 2*k + 7, b});
               k++;
            end
      end
   endtask

   task automatic step(input bit st, input bit r);
      bit exp_rd, exp_x, exp_w, exp_busy;
      rd_t e; ev_t v;
      @(posedge clk); cyc++; #1;
      // butterfly model: 5-cycle delay of x_nd/m_in
      bus.bf_y_nd  = dly_v[4];
      bus.bf_m_out = dly_v[4] ? dly_m[4] : '0;
      for (int i = 4; i > 0; i--) begin dly_v[i] = dly_v[i-1]; dly_m[i] = dly_m[i-1]; end
      dly_v[0] = 0;
      exp_busy = run_active && cyc > t0_run && cyc <= done_cyc;
      rst = r;
      bus.start = st;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
      bus.inverse = inv_next;
`endif
      if (r) begin rq.delete(); xq.delete(); wq.delete(); run_active = 0; exp_busy = 0; end
      else if (st && !exp_busy) sched(cyc);
      @(negedge clk);
      exp_busy = run_active && cyc > t0_run && cyc <= done_cyc;
      chk("busy", bus.busy, exp_busy);
      exp_rd = rq.size() > 0 && rq[0].cyc == cyc;
      chk("rd_en", bus.rd_en, exp_rd);
      if (exp_rd) begin
         e = rq.pop_front();
         chk("rd_addr_a", bus.rd_addr_a, e.a);
         chk("rd_addr_b", bus.rd_addr_b, e.b);
         chk("tw_addr", bus.tw_addr, e.tw);
         chk("stage", bus.stage, e.s);
         if (e.s == 0 && s0_first < 0) s0_first = cyc;
         if (e.s == 2 && s2_first < 0) s2_first = cyc;
      end
      exp_x = xq.size() > 0 && xq[0].cyc == cyc;
      chk("bf_x_nd", bus.bf_x_nd, exp_x);
      if (exp_x) begin v = xq.pop_front(); chk("bf_m_in", bus.bf_m_in, v.v); end
      exp_w = wq.size() > 0 && wq[0].cyc == cyc;
      chk("wr_en", bus.wr_en, exp_w);
      if (exp_w) begin v = wq.pop_front(); chk("wr_addr", bus.wr_addr, v.v); end
      chk("done", bus.done, run_active && cyc == done_cyc);
      if (bus.done === 1'b1) begin
         chk("done_lat", cyc - t0_run, 43);
         chk("s2_gap", s2_first - s0_first, 28);
      end
`ifdef FFT_STAGE_CTRL_INVERSE_EN
      if (exp_busy) chk("tw_conj", bus.tw_conj, inv_run);
`endif
      if (r) begin
         chk("rst_stage", bus.stage, 0);
         chk("rst_rd_addr_a", bus.rd_addr_a, 0);
         chk("rst_rd_addr_b", bus.rd_addr_b, 0);
         chk("rst_tw_addr", bus.tw_addr, 0);
         chk("rst_bf_m_in", bus.bf_m_in, 0);
         chk("rst_wr_addr", bus.wr_addr, 0);
      end
      dly_v[0] = bus.bf_x_nd;
      dly_m[0] = bus.bf_m_in;
   endtask

   initial begin
      rst = 1'b1; bus.start = 1'b0; bus.bf_y_nd = 1'b0; bus.bf_m_out = '0;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
      bus.inverse = 1'b0;
`endif
      for (int i = 0; i < 5; i++) begin dly_v[i] = 0; dly_m[i] = '0; end
      repeat (3) step(0, 1);                 // reset state
      repeat (2) step(0, 0);
      // run 1, with a start pulse while busy that must be ignored
      step(1, 0);
      for (int i = 1; i <= 43; i++) step(i == 7, 0);
      // run 2 starts the cycle after done, inverse requested
      inv_next = 1;
      step(1, 0);
      repeat (19) step(0, 0);                // now inside stage 1
      step(0, 1); step(0, 1);                // async reset mid-run
      repeat (8) step(0, 0);                 // in-flight results land in IDLE
      // run 3: full sequence from stage 0
      step(1, 0);
      repeat (50) step(0, 0);
      chk("rq_empty", rq.size(), 0);
      chk("xq_empty", xq.size(), 0);
      chk("wq_empty", wq.size(), 0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
Sequencer for one shared butterfly instance performing an in-place radix-2 DIT FFT over an N-point buffer.
- For each stage, generates buffer read addresses and twiddle ROM addresses, and issues butterflies at the butterfly's maximum rate (one per 2 cycles).
- Writes YA/YB back through a single write port.
- Drains the pipeline between stages so the next stage never reads stale data.
- Sits between the sample buffer (simple dual-port RAM, 1-cycle read latency), the twiddle ROM and the butterfly.

Parameters:
- LOG_N, 3, log2 of FFT length N; N = 1<<LOG_N; valid range 2..12.
- A_WDTH, LOG_N, buffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: one clock; reset is asynchronous and active-high.
- start  in  1  one-cycle request to run a full FFT; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last YB of the last stage has been written.
- stage  out  LOG_N-bit counter  current stage index s.
- rd_en  out  1  buffer read strobe.
- rd_addr_a  out  A_WDTH  XA read address.
- rd_addr_b  out  A_WDTH  XB read address.
- tw_addr  out  LOG_N-1 (min 1)  twiddle ROM index; ROM read in the same cycle as the buffer.
- bf_x_nd  out  1  to butterfly x_nd.
- bf_m_in  out  2*A_WDTH  to butterfly m_in; carries {addr_a, addr_b}.
- bf_m_out  in  2*A_WDTH  from butterfly m_out.
- bf_y_nd  in  1  from butterfly y_nd.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  A_WDTH  buffer write address; data path goes butterfly y to RAM directly.

Behaviour:
- Reset values: all outputs 0; state IDLE; stage 0; counters 0.
- Reset mid-run: abort immediately and return to IDLE. No done pulse. Buffer contents undefined.
- States:
  - IDLE: start=1 → ISSUE, s=0, k=0.
  - ISSUE: even phase drives rd_en=1 with the addresses of butterfly k. The following cycle drives bf_x_nd=1 and bf_m_in={addr_a, addr_b} of k, then k++. After k=N/2-1 issues → DRAIN.
  - DRAIN: wait until outstanding==0. Then, if s==LOG_N-1 → DONE; else s++, k=0 → ISSUE. The first read of the next stage occurs the cycle after the last YB write.
  - DONE: done=1 for one cycle → IDLE.
- Address rule, per stage s and butterfly k, with half=1<<s and pos=k&(half-1):
  - addr_a = ((k>>s)<<(s+1)) | pos
  - addr_b = addr_a + half
  - tw_addr = pos << (LOG_N-1-s)
- Timing: butterfly k read at relative cycle 2k, x_nd at 2k+1, bf_y_nd at 2k+6.
  - YA write at 2k+6: wr_en=1, wr_addr=bf_m_out[2*A_WDTH-1:A_WDTH]; the controller latches bf_m_out[A_WDTH-1:0] at the same time.
  - YB write at 2k+7: wr_en=1, wr_addr=latched addr_b.
- outstanding counter: +1 on bf_x_nd, -1 on the YB write cycle; both in the same cycle leaves it unchanged.
- Stage period is N+6 cycles. done asserts at cycle 1+LOG_N*(N+6) after the start cycle (N=8: 43).
- bf_x_nd is never asserted on consecutive cycles.
- bf_y_nd is ignored in IDLE.
- A bf_y_nd seen while outstanding==0 sets an internal err sticky bit, cleared by rst.

Optional Feature:
FFT_STAGE_CTRL_INVERSE_EN
- With it: adds input inverse (sampled on accepted start) and output tw_conj (registered, held for the whole run). tw_conj=1 tells the twiddle ROM wrapper to conjugate W, giving an IFFT.
- Without it: no ports added; forward FFT only.

Decomposition:
- Shared package fft_pkg:
  - LOG_N-derived widths: A_WDTH, TW_WDTH.
  - State encoding constants: IDLE, ISSUE, DRAIN, DONE.
  - Pipeline constants: BF_LATENCY=5, ISSUE_INTERVAL=2.
- Sub-module fft_addr_gen: combinational mapping (s, k) → (addr_a, addr_b, tw_addr), verified standalone.

Test Plan:
- N=8, start pulse: stage 0 reads (0,1),(2,3),(4,5),(6,7) with tw 0 → writes occur in the same order, YA then YB, each pair on consecutive cycles.
- N=8, stage 2: reads (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3; first stage-2 read 28 cycles after the first stage-0 read; done exactly 43 cycles after start.
- Drain check: no rd_en between the last x_nd of a stage and the final YB write; outstanding returns to 0 before each new stage.
- start re-asserted while busy=1 → ignored; a start one cycle after done → new run with identical timing.
- rst asserted mid-stage 1 → all outputs 0 asynchronously; the next start runs a full 43-cycle sequence from stage 0.
- With FFT_STAGE_CTRL_INVERSE_EN, inverse=1 at start → tw_conj=1 for the whole run; end-to-end FFT followed by IFFT of impulse at index 0 recovers the scaled impulse (butterfly halves per stage).
